fc_argmax: RTL and testbench
============================

FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 Parameters SHALL be: NUM_CLASSES, default 10, number of fully-connected output neurons; SCORE_W, default 38, signed score width; IDX_W, default 4, class index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  level run request, same semantics as the FC neuron enables; low = clear and idle.
REQ-005 done_vec  input  NUM_CLASSES  per-neuron done flags (bit k = done of fc neuron k).
REQ-006 score_flat  input  NUM_CLASSES*SCORE_W  signed neuron outputs, neuron k at bits [k*SCORE_W +: SCORE_W].
REQ-007 class_idx  output  IDX_W  index of the winning neuron.
REQ-008 max_score  output  SCORE_W  signed score of the winning neuron.
REQ-009 busy  output  1  high in LATCH and SCAN states.
REQ-010 done_cls  output  1  result valid; high only in DONE state.

Function
REQ-011 FSM states SHALL be IDLE, WAIT, LATCH, SCAN, DONE.
REQ-012 IDLE -> WAIT when enable=1; WAIT -> LATCH when enable=1 and done_vec all ones on the same edge.
REQ-013 LATCH (1 cycle) SHALL copy all NUM_CLASSES scores into an internal register array, set running max = score 0, running idx = 0, scan counter = 1.
REQ-014 SCAN SHALL compare one latched score per cycle (counter 1..NUM_CLASSES-1); on strict signed greater-than, update running max and idx; counter increments each cycle.
REQ-015 SCAN -> DONE on the edge that processes counter = NUM_CLASSES-1; class_idx/max_score SHALL be loaded on that edge and done_cls rise with them.
REQ-016 Latency: done_cls SHALL rise on the 10th rising edge after the edge that samples enable=1 and done_vec all ones (NUM_CLASSES=10).
REQ-017 Ties: lowest index SHALL win (strict comparison only).
REQ-018 Comparison SHALL be full-width signed; no saturation, truncation or ReLU.
REQ-019 After LATCH, changes on score_flat or done_vec SHALL NOT affect the result.
REQ-020 DONE SHALL hold outputs stable while enable=1; a new classification requires enable to go low then high.
REQ-021 enable=0 in any state SHALL force IDLE on the next edge and clear class_idx, max_score, done_cls, busy to 0.
REQ-022 done_vec partially set in WAIT: SHALL remain in WAIT indefinitely, outputs 0.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force IDLE and class_idx=0, max_score=0, busy=0, done_cls=0, counter=0, score registers=0.
REQ-024 Reset assertion mid-SCAN SHALL abandon the scan; after release the block SHALL start from IDLE with no residual result.

Structure
REQ-025 Shared package cnn_pkg SHALL hold NUM_CLASSES, SCORE_W, IDX_W defaults and the FSM state enum type.
REQ-026 Block SHALL be flat: no sub-module (single comparator, inline).

Verification
REQ-027 Scores 0..9 = {5,-3,12,7,0,12,-100,1,2,3}, all done -> class_idx=2, max_score=12 (tie with 5 resolved low), done_cls after exactly 10 edges.
REQ-028 All scores = -2^37 (most negative) -> class_idx=0, max_score=-2^37; score 9 = 2^37-1, rest 0 -> class_idx=9, max_score=2^37-1.
REQ-029 done_vec=0x1FF held 50 cycles -> busy=0, done_cls=0; set bit 9 -> done_cls 10 edges later.
REQ-030 Change score_flat to make neuron 4 largest during SCAN -> result unchanged from latched values.
REQ-031 rst_n low at SCAN counter=5 -> all outputs 0 immediately; enable dropped in DONE -> outputs cleared next edge, IDLE.
REQ-032 Back-to-back runs with enable toggled low one cycle between -> second result reflects second score set, latency 10 edges after re-entry into WAIT with all done.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN classifier defaults and the argmax FSM state type.
package cnn_pkg;

   localparam int unsigned CNN_NUM_CLASSES = 10;
   localparam int unsigned CNN_SCORE_W     = 38;
   localparam int unsigned CNN_IDX_W       = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_LATCH = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DONE  = 3'd4
   } argmax_state_e;

endpackage : cnn_pkg

// File: rtl/fc_argmax.sv
// Sequential argmax over the fully-connected layer outputs: waits for every
// neuron to finish, snapshots all scores, then walks them one per cycle with
// a single signed comparator. Ties keep the lower index.
module fc_argmax
   import cnn_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
   parameter int unsigned SCORE_W     = CNN_SCORE_W,
   parameter int unsigned IDX_W       = CNN_IDX_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [NUM_CLASSES-1:0]         done_vec,
   input  logic [NUM_CLASSES*SCORE_W-1:0] score_flat,
   output logic [IDX_W-1:0]               class_idx,
   output logic [SCORE_W-1:0]             max_score,
   output logic                           busy,
   output logic                           done_cls
);

   argmax_state_e             r_state;
   argmax_state_e             w_state_nxt;

   logic signed [SCORE_W-1:0] r_scores [NUM_CLASSES];
   logic signed [SCORE_W-1:0] r_max;
   logic        [IDX_W-1:0]   r_idx;
   logic        [IDX_W-1:0]   r_cnt;
   logic        [IDX_W-1:0]   r_class_idx;
   logic        [SCORE_W-1:0] r_max_score;
   logic                      r_busy;
   logic                      r_done;

   logic signed [SCORE_W-1:0] w_cand;
   logic                      w_gt;
   logic                      w_last;
   logic signed [SCORE_W-1:0] w_new_max;
   logic        [IDX_W-1:0]   w_new_idx;

   // Single comparator: strict greater-than so the earliest maximum is kept.
   always_comb begin
      w_cand    = r_scores[r_cnt];
      w_gt      = (w_cand > r_max);
      w_last    = (r_cnt == IDX_W'(NUM_CLASSES - 1));
      w_new_max = w_gt ? w_cand : r_max;
      w_new_idx = w_gt ? r_cnt  : r_idx;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; dropping enable returns to IDLE from anywhere.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (enable) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!enable)        w_state_nxt = ST_IDLE;
            else if (&done_vec) w_state_nxt = ST_LATCH;
         end
         ST_LATCH: w_state_nxt = enable ? ST_SCAN : ST_IDLE;
         ST_SCAN: begin
            if (!enable)    w_state_nxt = ST_IDLE;
            else if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE:  if (!enable) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Snapshot, scan datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_CLASSES; k++) r_scores[k] <= '0;
         r_max       <= '0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_class_idx <= '0;
         r_max_score <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_LATCH) || (w_state_nxt == ST_SCAN);
         r_done <= (w_state_nxt == ST_DONE);
         if (!enable) begin
            r_max       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_class_idx <= '0;
            r_max_score <= '0;
         end else begin
            case (r_state)
               ST_LATCH: begin
                  for (int unsigned k = 0; k < NUM_CLASSES; k++)
                     r_scores[k] <= score_flat[k*SCORE_W +: SCORE_W];
                  r_max <= score_flat[0 +: SCORE_W];
                  r_idx <= '0;
                  r_cnt <= IDX_W'(1);
               end
               ST_SCAN: begin
                  r_max <= w_new_max;
                  r_idx <= w_new_idx;
                  if (w_last) begin
                     r_class_idx <= w_new_idx;
                     r_max_score <= w_new_max;
                  end else begin
                     r_cnt <= r_cnt + IDX_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign class_idx = r_class_idx;
   assign max_score = r_max_score;
   assign busy      = r_busy;
   assign done_cls  = r_done;

endmodule : fc_argmax

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax with hand-computed expected results.
module tb_fc_argmax;

   localparam int unsigned NC = 10;
   localparam int unsigned SW = 38;
   localparam int unsigned IW = 4;

   localparam logic [SW-1:0] S_NEG = {1'b1, {(SW-1){1'b0}}};
   localparam logic [SW-1:0] S_POS = {1'b0, {(SW-1){1'b1}}};

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic [NC-1:0]      done_vec;
   logic [NC*SW-1:0]   score_flat;
   logic [IW-1:0]      class_idx;
   logic [SW-1:0]      max_score;
   logic               busy;
   logic               done_cls;

   logic signed [SW-1:0] sc [NC];
   int n_vec;
   int n_err;
   int lat;
   int busy_seen;

   fc_argmax dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .done_vec   (done_vec),
      .score_flat (score_flat),
      .class_idx  (class_idx),
      .max_score  (max_score),
      .busy       (busy),
      .done_cls   (done_cls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_scores();
      for (int k = 0; k < NC; k++) score_flat[k*SW +: SW] = sc[k];
   endtask

   // Drop enable one cycle, raise it with all neurons done, and count edges
   // from the WAIT->LATCH edge until done_cls rises.
   task automatic start_run();
      enable   = 1'b0;
      done_vec = '1;
      load_scores();
      step();
      enable = 1'b1;
      step();          // IDLE -> WAIT
      step();          // WAIT samples all done -> LATCH
   endtask

   task automatic wait_done(input string tag);
      lat = 0;
      while (!done_cls && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(10));
   endtask

   task automatic run_case(input string tag, input logic [IW-1:0] e_idx, input logic [SW-1:0] e_max);
      start_run();
      wait_done(tag);
      check({tag, "_idx"}, 64'(class_idx), 64'(e_idx));
      check({tag, "_max"}, 64'(max_score), 64'(e_max));
   endtask

   task automatic set_ref();
      sc[0] = 38'sd5;   sc[1] = -38'sd3; sc[2] = 38'sd12; sc[3] = 38'sd7;
      sc[4] = 38'sd0;   sc[5] = 38'sd12; sc[6] = -38'sd100; sc[7] = 38'sd1;
      sc[8] = 38'sd2;   sc[9] = 38'sd3;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      enable = 1'b0;
      done_vec = '0;
      score_flat = '0;
      for (int k = 0; k < NC; k++) sc[k] = '0;
      step();
      step();
      check("rst_idx",  64'(class_idx), 64'(0));
      check("rst_max",  64'(max_score), 64'(0));
      check("rst_busy", 64'(busy),      64'(0));
      check("rst_done", 64'(done_cls),  64'(0));
      rst_n = 1'b1;
      step();

      // Reference vector: tie between 2 and 5 resolves to 2.
      set_ref();
      start_run();
      step();
      check("ref_busy_latch", 64'(busy), 64'(1));
      lat = 1;
      while (!done_cls && lat < 20) begin
         step();
         lat++;
      end
      check("ref_latency", 64'(lat), 64'(10));
      check("ref_idx", 64'(class_idx), 64'(2));
      check("ref_max", 64'(max_score), 64'(12));
      check("ref_busy_done", 64'(busy), 64'(0));

      // Outputs hold in DONE while enable stays high.
      step(); step(); step();
      check("hold_done", 64'(done_cls),  64'(1));
      check("hold_idx",  64'(class_idx), 64'(2));
      check("hold_max",  64'(max_score), 64'(12));

      // Enable dropped in DONE clears on the next edge.
      enable = 1'b0;
      step();
      check("drop_done", 64'(done_cls),  64'(0));
      check("drop_idx",  64'(class_idx), 64'(0));
      check("drop_max",  64'(max_score), 64'(0));

      // All most-negative scores: index 0 wins.
      for (int k = 0; k < NC; k++) sc[k] = S_NEG;
      run_case("neg", 4'd0, S_NEG);

      // Only the last neuron is largest.
      for (int k = 0; k < NC; k++) sc[k] = '0;
      sc[9] = S_POS;
      run_case("pos9", 4'd9, S_POS);

      // Back-to-back: the second score set replaces the first result.
      for (int k = 0; k < NC; k++) sc[k] = -38'sd50;
      sc[6] = -38'sd7;
      sc[7] = -38'sd7;
      run_case("b2b", 4'd6, -38'sd7);

      // Partial done flags keep the block parked in WAIT.
      set_ref();
      enable   = 1'b0;
      done_vec = 10'h1FF;
      load_scores();
      step();
      enable = 1'b1;
      busy_seen = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (busy || done_cls) busy_seen++;
      end
      check("partial_activity", 64'(busy_seen), 64'(0));
      check("partial_idx", 64'(class_idx), 64'(0));
      done_vec = '1;
      step();
      wait_done("partial");
      check("partial_idx_final", 64'(class_idx), 64'(2));

      // Scores changed mid-scan are ignored.
      set_ref();
      start_run();
      step();          // LATCH -> SCAN, snapshot taken
      step();
      sc[4] = 38'sd1000;
      load_scores();
      done_vec = '0;
      lat = 2;
      while (!done_cls && lat < 20) begin
         step();
         lat++;
      end
      check("late_latency", 64'(lat), 64'(10));
      check("late_idx", 64'(class_idx), 64'(2));
      check("late_max", 64'(max_score), 64'(12));

      // Async reset mid-scan (counter = 5) clears immediately.
      set_ref();
      start_run();
      for (int c = 0; c < 5; c++) step();
      check("mid_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy),      64'(0));
      check("arst_done", 64'(done_cls),  64'(0));
      check("arst_idx",  64'(class_idx), 64'(0));
      check("arst_max",  64'(max_score), 64'(0));
      step();
      rst_n = 1'b1;
      enable = 1'b1;
      step();
      step();
      check("post_rst_idx",  64'(class_idx), 64'(0));
      check("post_rst_done", 64'(done_cls),  64'(0));
      sc[0] = 38'sd40;
      run_case("post_rst", 4'd0, 38'sd40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fc_argmax
